// File: rtl/jesd204_rx_sh_stream_lock.sv
// JESD204C 64b66b receive stage: extracts the sync-header stream, locks to the 32-block
// multiblock via the pilot pattern and tags each forwarded block with its multiblock index.
module jesd204_rx_sh_stream_lock #(
    parameter int unsigned LOCK_LOSS_CNT = 4
) (
    input  logic        usr_clk,
    input  logic        usr_rstn,
    input  logic        i_valid,
    input  logic [63:0] i_data,
    input  logic [1:0]  i_header,
    input  logic        i_block_sync,
    output logic        o_valid,
    output logic [63:0] o_data,
    output logic [1:0]  o_header,
    output logic [4:0]  o_mb_idx,
    output logic        o_eomb,
    output logic        o_eoemb,
    output logic [11:0] o_crc12,
    output logic [6:0]  o_cmd,
    output logic        o_lock,
    output logic [7:0]  o_err_cnt
);

    localparam logic [3:0] LossCnt = 4'(LOCK_LOSS_CNT);

    typedef enum logic [1:0] {StReset, StHunt, StLocked} state_e;

    state_e      state_q;
    logic [31:0] win_q;
    logic [31:0] inv_win_q;
    logic        inv_mb_q;
    logic [4:0]  idx_q;
    logic [3:0]  run_q;

    logic        sync_bit;
    logic        hdr_bad;
    logic [31:0] win_next;
    logic [31:0] inv_win_next;
    logic [4:0]  idx_cur;
    logic        inv_flag;
    logic        pilot_good;
    logic [11:0] crc_next;
    logic [6:0]  cmd_next;
    logic [3:0]  run_inc;

    always_comb begin
        sync_bit     = (i_header == 2'b10);
        hdr_bad      = (i_header == 2'b00) || (i_header == 2'b11);
        // b31 is the newest bit; b0 is the oldest and falls out on the next shift.
        win_next     = {sync_bit, win_q[31:1]};
        inv_win_next = {hdr_bad, inv_win_q[31:1]};
        idx_cur      = idx_q + 5'd1;
        run_inc      = run_q + 4'd1;

        // Locked: invalid scope is the current multiblock. Hunting: any invalid bit in window.
        if (state_q == StLocked) begin
            inv_flag = ((idx_cur == 5'd0) ? 1'b0 : inv_mb_q) | hdr_bad;
        end else begin
            inv_flag = |inv_win_next;
        end

        pilot_good = win_next[3] & win_next[7] & win_next[11] & win_next[15] &
                     win_next[19] & win_next[23] & win_next[26] &
                     (win_next[30:27] == 4'b0000) & win_next[31] & ~inv_flag;

        crc_next = {win_next[0],  win_next[1],  win_next[2],
                    win_next[4],  win_next[5],  win_next[6],
                    win_next[8],  win_next[9],  win_next[10],
                    win_next[12], win_next[13], win_next[14]};
        cmd_next = {win_next[16], win_next[17], win_next[18],
                    win_next[20], win_next[21], win_next[22],
                    win_next[24]};
    end

    always_ff @(posedge usr_clk) begin
        if (!usr_rstn) begin
            state_q   <= StReset;
            win_q     <= '0;
            inv_win_q <= '0;
            inv_mb_q  <= 1'b0;
            idx_q     <= '0;
            run_q     <= '0;
            o_valid   <= 1'b0;
            o_data    <= '0;
            o_header  <= '0;
            o_mb_idx  <= '0;
            o_eomb    <= 1'b0;
            o_eoemb   <= 1'b0;
            o_crc12   <= '0;
            o_cmd     <= '0;
            o_lock    <= 1'b0;
            o_err_cnt <= '0;
        end else begin
            o_valid  <= i_valid;
            o_data   <= i_data;
            o_header <= i_header;
            o_eomb   <= 1'b0;
            o_eoemb  <= 1'b0;

            if (!i_block_sync) begin
                // Loss of block alignment overrides any pilot on this block.
                state_q   <= StHunt;
                win_q     <= '0;
                inv_win_q <= '0;
                inv_mb_q  <= 1'b0;
                idx_q     <= '0;
                run_q     <= '0;
                o_mb_idx  <= '0;
                o_lock    <= 1'b0;
            end else if (i_valid) begin
                win_q     <= win_next;
                inv_win_q <= inv_win_next;
                case (state_q)
                    StReset, StHunt: begin
                        if (pilot_good) begin
                            state_q  <= StLocked;
                            idx_q    <= 5'd31;
                            inv_mb_q <= 1'b0;
                            run_q    <= '0;
                            o_mb_idx <= 5'd31;
                            o_lock   <= 1'b1;
                            o_eomb   <= 1'b1;
                            o_eoemb  <= win_next[25];
                            o_crc12  <= crc_next;
                            o_cmd    <= cmd_next;
                        end else begin
                            state_q <= StHunt;
                        end
                    end
                    StLocked: begin
                        idx_q    <= idx_cur;
                        inv_mb_q <= inv_flag;
                        o_mb_idx <= idx_cur;
                        if (idx_cur == 5'd31) begin
                            if (pilot_good) begin
                                run_q   <= '0;
                                o_eomb  <= 1'b1;
                                o_eoemb <= win_next[25];
                                o_crc12 <= crc_next;
                                o_cmd   <= cmd_next;
                            end else begin
                                if (o_err_cnt != 8'hFF) begin
                                    o_err_cnt <= o_err_cnt + 8'd1;
                                end
                                if (run_inc == LossCnt) begin
                                    state_q  <= StHunt;
                                    run_q    <= '0;
                                    idx_q    <= '0;
                                    o_mb_idx <= '0;
                                    o_lock   <= 1'b0;
                                end else begin
                                    run_q <= run_inc;
                                end
                            end
                        end
                    end
                    default: begin
                        state_q <= StHunt;
                    end
                endcase
            end else if (state_q == StReset) begin
                state_q <= StHunt;
            end
        end
    end

endmodule

// File: tb/tb_jesd204_rx_sh_stream_lock.sv
// Directed bench for jesd204_rx_sh_stream_lock: pilot lock, EoEMB, lock loss, invalid headers,
// valid gaps, block-sync loss and mid-lock reset.
module tb_jesd204_rx_sh_stream_lock;

    logic        usr_clk = 1'b0;
    logic        usr_rstn;
    logic        i_valid;
    logic [63:0] i_data;
    logic [1:0]  i_header;
    logic        i_block_sync;
    logic        o_valid;
    logic [63:0] o_data;
    logic [1:0]  o_header;
    logic [4:0]  o_mb_idx;
    logic        o_eomb;
    logic        o_eoemb;
    logic [11:0] o_crc12;
    logic [6:0]  o_cmd;
    logic        o_lock;
    logic [7:0]  o_err_cnt;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [7:0]  exp_err = '0;
    logic [11:0] exp_crc = '0;
    logic [6:0]  exp_cmd = '0;
    logic [31:0] blk_cnt = '0;
    logic [63:0] sent_data = '0;

    always #5 usr_clk = ~usr_clk;

    jesd204_rx_sh_stream_lock #(.LOCK_LOSS_CNT(4)) dut (
        .usr_clk      (usr_clk),
        .usr_rstn     (usr_rstn),
        .i_valid      (i_valid),
        .i_data       (i_data),
        .i_header     (i_header),
        .i_block_sync (i_block_sync),
        .o_valid      (o_valid),
        .o_data       (o_data),
        .o_header     (o_header),
        .o_mb_idx     (o_mb_idx),
        .o_eomb       (o_eomb),
        .o_eoemb      (o_eoemb),
        .o_crc12      (o_crc12),
        .o_cmd        (o_cmd),
        .o_lock       (o_lock),
        .o_err_cnt    (o_err_cnt)
    );

    // Sync-header bits of one multiblock, b0 first.
    function automatic logic [31:0] mb_bits(input logic [11:0] crc, input logic [6:0] cmd,
                                            input logic eo, input logic bad30);
        logic [31:0] b;
        b = '0;
        b[0]  = crc[11]; b[1]  = crc[10]; b[2]  = crc[9];  b[3]  = 1'b1;
        b[4]  = crc[8];  b[5]  = crc[7];  b[6]  = crc[6];  b[7]  = 1'b1;
        b[8]  = crc[5];  b[9]  = crc[4];  b[10] = crc[3];  b[11] = 1'b1;
        b[12] = crc[2];  b[13] = crc[1];  b[14] = crc[0];  b[15] = 1'b1;
        b[16] = cmd[6];  b[17] = cmd[5];  b[18] = cmd[4];  b[19] = 1'b1;
        b[20] = cmd[3];  b[21] = cmd[2];  b[22] = cmd[1];  b[23] = 1'b1;
        b[24] = cmd[0];  b[25] = eo;      b[26] = 1'b1;    b[30] = bad30;
        b[31] = 1'b1;
        return b;
    endfunction

    // Drives one cycle and returns 1 time unit after the edge, with outputs for that beat settled.
    task automatic drive(input logic v, input logic [1:0] hdr);
        i_valid   = v;
        i_header  = hdr;
        i_data    = {blk_cnt, ~blk_cnt};
        sent_data = i_data;
        blk_cnt   = blk_cnt + 32'd1;
        @(posedge usr_clk);
        #1;
    endtask

    task automatic test_reset;
        usr_rstn     = 1'b0;
        i_block_sync = 1'b0;
        drive(1'b1, 2'b10);
        drive(1'b0, 2'b00);
        n_vec++;
        if ({o_valid, o_data, o_header, o_mb_idx, o_eomb, o_eoemb, o_crc12, o_cmd, o_lock,
             o_err_cnt} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got valid=%b data=%h hdr=%b idx=%0d eomb=%b lock=%b err=%0d, expected all 0",
                     o_valid, o_data, o_header, o_mb_idx, o_eomb, o_lock, o_err_cnt);
        end
        usr_rstn     = 1'b1;
        i_block_sync = 1'b1;
        drive(1'b0, 2'b00);
    endtask

    task automatic test_acquire;
        logic [31:0] bits;
        logic [8:0]  exp;
        bits = mb_bits(12'hA5C, 7'h3B, 1'b0, 1'b0);
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 32; i++) begin
                drive(1'b1, bits[i] ? 2'b10 : 2'b01);
                if (m == 0) exp = (i == 31) ? {4'b1110, 5'd31} : {4'b1000, 5'd0};
                else        exp = {1'b1, 1'b1, i == 31, 1'b0, 5'(i)};
                n_vec++;
                if ({o_valid, o_lock, o_eomb, o_eoemb, o_mb_idx} !== exp) begin
                    n_bad++;
                    $display("FAIL acquire_mb%0d_blk%0d: got v/lock/eomb/eoemb/idx=%b expected %b",
                             m, i, {o_valid, o_lock, o_eomb, o_eoemb, o_mb_idx}, exp);
                end
            end
            n_vec++;
            if (o_crc12 !== 12'hA5C || o_cmd !== 7'h3B) begin
                n_bad++;
                $display("FAIL acquire_fields_mb%0d: got crc=%h cmd=%h expected crc=a5c cmd=3b",
                         m, o_crc12, o_cmd);
            end
        end
        n_vec++;
        if (o_data !== sent_data || o_header !== 2'b10) begin
            n_bad++;
            $display("FAIL acquire_passthru: got data=%h hdr=%b expected data=%h hdr=10",
                     o_data, o_header, sent_data);
        end
        exp_crc = 12'hA5C;
        exp_cmd = 7'h3B;
    endtask

    task automatic test_eoemb;
        logic [31:0] bits;
        logic [11:0] crc;
        logic [6:0]  cmd;
        logic        eo;
        for (int m = 0; m < 8; m++) begin
            crc  = 12'h100 + 12'(m);
            cmd  = 7'h40 | 7'(m);
            eo   = (m % 4 == 3);
            bits = mb_bits(crc, cmd, eo, 1'b0);
            for (int i = 0; i < 32; i++) begin
                drive(1'b1, bits[i] ? 2'b10 : 2'b01);
                n_vec++;
                if ({o_lock, o_eomb, o_eoemb, o_mb_idx} !== {1'b1, i == 31, eo && i == 31, 5'(i)})
                begin
                    n_bad++;
                    $display("FAIL eoemb_mb%0d_blk%0d: got lock/eomb/eoemb/idx=%b expected %b",
                             m, i, {o_lock, o_eomb, o_eoemb, o_mb_idx},
                             {1'b1, i == 31, eo && i == 31, 5'(i)});
                end
            end
            n_vec++;
            if (o_crc12 !== crc || o_cmd !== cmd) begin
                n_bad++;
                $display("FAIL eoemb_fields_mb%0d: got crc=%h cmd=%h expected crc=%h cmd=%h",
                         m, o_crc12, o_cmd, crc, cmd);
            end
            exp_crc = crc;
            exp_cmd = cmd;
        end
    endtask

    task automatic test_lock_loss;
        logic [31:0] bits;
        logic        bad;
        logic [8:0]  exp;
        for (int r = 0; r < 8; r++) begin
            bad  = (r != 3);
            bits = mb_bits(12'hA5C, 7'h3B, 1'b0, bad);
            for (int i = 0; i < 32; i++) begin
                drive(1'b1, bits[i] ? 2'b10 : 2'b01);
                if (i != 31)     exp = {1'b1, 1'b1, 1'b0, 1'b0, 5'(i)};
                else if (!bad)   exp = {4'b1110, 5'd31};
                else if (r == 7) exp = {4'b1000, 5'd0};
                else             exp = {4'b1100, 5'd31};
                n_vec++;
                if ({o_valid, o_lock, o_eomb, o_eoemb, o_mb_idx} !== exp) begin
                    n_bad++;
                    $display("FAIL lockloss_mb%0d_blk%0d: got v/lock/eomb/eoemb/idx=%b expected %b",
                             r, i, {o_valid, o_lock, o_eomb, o_eoemb, o_mb_idx}, exp);
                end
            end
            if (bad) begin
                exp_err = exp_err + 8'd1;
            end else begin
                exp_crc = 12'hA5C;
                exp_cmd = 7'h3B;
            end
            n_vec++;
            if (o_err_cnt !== exp_err || o_crc12 !== exp_crc || o_cmd !== exp_cmd) begin
                n_bad++;
                $display("FAIL lockloss_status_mb%0d: got err=%0d crc=%h cmd=%h expected err=%0d crc=%h cmd=%h",
                         r, o_err_cnt, o_crc12, o_cmd, exp_err, exp_crc, exp_cmd);
            end
        end
        bits = mb_bits(12'hA5C, 7'h3B, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, bits[i] ? 2'b10 : 2'b01);
            exp = (i == 31) ? {4'b1110, 5'd31} : {4'b1000, 5'd0};
            n_vec++;
            if ({o_valid, o_lock, o_eomb, o_eoemb, o_mb_idx} !== exp) begin
                n_bad++;
                $display("FAIL relock_blk%0d: got v/lock/eomb/eoemb/idx=%b expected %b",
                         i, {o_valid, o_lock, o_eomb, o_eoemb, o_mb_idx}, exp);
            end
        end
    endtask

    task automatic test_invalid_hdr;
        logic [31:0] bits;
        bits = mb_bits(12'hA5C, 7'h3B, 1'b0, 1'b0);
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 32; i++) begin
                if (m == 0 && i == 5) drive(1'b1, 2'b11);
                else                  drive(1'b1, bits[i] ? 2'b10 : 2'b01);
            end
            if (m == 0) exp_err = exp_err + 8'd1;
            n_vec++;
            if ({o_lock, o_eomb, o_mb_idx, o_err_cnt} !== {1'b1, m == 1, 5'd31, exp_err}) begin
                n_bad++;
                $display("FAIL invalid_hdr_mb%0d: got lock=%b eomb=%b idx=%0d err=%0d expected lock=1 eomb=%b idx=31 err=%0d",
                         m, o_lock, o_eomb, o_mb_idx, o_err_cnt, m == 1, exp_err);
            end
        end
    endtask

    task automatic test_gaps;
        logic [31:0] bits;
        int          ngap;
        bits = mb_bits(12'hA5C, 7'h3B, 1'b1, 1'b0);
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 32; i++) begin
                ngap = (i == 0 || i == 31 || $urandom_range(0, 3) == 0) ? 2 : 0;
                for (int g = 0; g < ngap; g++) begin
                    drive(1'b0, 2'b11);
                    n_vec++;
                    if ({o_valid, o_lock, o_eomb, o_eoemb, o_mb_idx} !==
                        {4'b0100, 5'((i + 31) % 32)}) begin
                        n_bad++;
                        $display("FAIL gap_mb%0d_blk%0d: got v/lock/eomb/eoemb/idx=%b expected %b",
                                 m, i, {o_valid, o_lock, o_eomb, o_eoemb, o_mb_idx},
                                 {4'b0100, 5'((i + 31) % 32)});
                    end
                end
                drive(1'b1, bits[i] ? 2'b10 : 2'b01);
                n_vec++;
                if ({o_valid, o_lock, o_eomb, o_eoemb, o_mb_idx} !==
                    {1'b1, 1'b1, i == 31, i == 31, 5'(i)}) begin
                    n_bad++;
                    $display("FAIL gap_beat_mb%0d_blk%0d: got v/lock/eomb/eoemb/idx=%b expected %b",
                             m, i, {o_valid, o_lock, o_eomb, o_eoemb, o_mb_idx},
                             {1'b1, 1'b1, i == 31, i == 31, 5'(i)});
                end
            end
        end
    endtask

    task automatic test_sync_loss;
        logic [31:0] bits;
        bits = mb_bits(12'hA5C, 7'h3B, 1'b0, 1'b0);
        for (int i = 0; i < 31; i++) drive(1'b1, bits[i] ? 2'b10 : 2'b01);
        i_block_sync = 1'b0;
        drive(1'b1, 2'b10);
        n_vec++;
        if ({o_valid, o_lock, o_eomb, o_eoemb, o_mb_idx, o_err_cnt} !== {4'b1000, 5'd0, exp_err})
        begin
            n_bad++;
            $display("FAIL sync_loss: got v=%b lock=%b eomb=%b idx=%0d err=%0d expected v=1 lock=0 eomb=0 idx=0 err=%0d",
                     o_valid, o_lock, o_eomb, o_mb_idx, o_err_cnt, exp_err);
        end
        i_block_sync = 1'b1;
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, bits[i] ? 2'b10 : 2'b01);
            n_vec++;
            if ({o_lock, o_eomb} !== {i == 31, i == 31}) begin
                n_bad++;
                $display("FAIL sync_relock_blk%0d: got lock=%b eomb=%b expected %b",
                         i, o_lock, o_eomb, i == 31);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] bits;
        bits = mb_bits(12'hA5C, 7'h3B, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b1, bits[i] ? 2'b10 : 2'b01);
        usr_rstn = 1'b0;
        drive(1'b1, bits[10] ? 2'b10 : 2'b01);
        usr_rstn = 1'b1;
        exp_err  = '0;
        n_vec++;
        if ({o_valid, o_data, o_header, o_mb_idx, o_eomb, o_eoemb, o_crc12, o_cmd, o_lock,
             o_err_cnt} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid: got valid=%b idx=%0d eomb=%b crc=%h cmd=%h lock=%b err=%0d, expected all 0",
                     o_valid, o_mb_idx, o_eomb, o_crc12, o_cmd, o_lock, o_err_cnt);
        end
        // Partial multiblock after reset must not lock; the following full one must.
        for (int i = 11; i < 32; i++) drive(1'b1, bits[i] ? 2'b10 : 2'b01);
        n_vec++;
        if ({o_lock, o_eomb} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_partial: got lock=%b eomb=%b expected 0 0", o_lock, o_eomb);
        end
        for (int i = 0; i < 32; i++) drive(1'b1, bits[i] ? 2'b10 : 2'b01);
        n_vec++;
        if ({o_lock, o_eomb, o_mb_idx, o_crc12, o_err_cnt} !== {2'b11, 5'd31, 12'hA5C, 8'd0})
        begin
            n_bad++;
            $display("FAIL reset_relock: got lock=%b eomb=%b idx=%0d crc=%h err=%0d expected 1 1 31 a5c 0",
                     o_lock, o_eomb, o_mb_idx, o_crc12, o_err_cnt);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        usr_rstn     = 1'b0;
        i_valid      = 1'b0;
        i_data       = '0;
        i_header     = 2'b00;
        i_block_sync = 1'b0;
        test_reset();
        test_acquire();
        test_eoemb();
        test_lock_loss();
        test_invalid_hdr();
        test_gaps();
        test_sync_loss();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
